// File: rtl/fir_decim_fifo.sv
// Decimating output stage for the low-pass FIR: keeps one of every DECIM samples,
// applies a saturating power-of-two gain and buffers results in a fall-through FIFO.
module fir_decim_fifo #(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned DECIM      = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    input  logic [2:0]                    gain_shift,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          sat,
    input  logic                          clr_flags
);

    localparam int unsigned EXT_W = DATA_W + 7;
    localparam int unsigned PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX = {{8{1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{8{1'b1}}, {(DATA_W-1){1'b0}}};

    logic [PH_W-1:0]         phase;
    logic [PH_W-1:0]         phase_next_c;
    logic                    keep_c;

    logic signed [EXT_W-1:0] ext_c;
    logic signed [EXT_W-1:0] shifted_c;
    logic [DATA_W-1:0]       gain_data_c;
    logic                    gain_clip_c;

    logic [DATA_W-1:0]       stage_data;
    logic                    stage_valid;
    logic                    stage_clip;

    logic [DATA_W-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           wr_next_c;
    logic [AW-1:0]           rd_next_c;
    logic [LW-1:0]           level_next_c;
    logic [DATA_W-1:0]       head_next_c;
    logic                    pop_c;
    logic                    push_c;
    logic                    drop_c;

    // Decimation phase: only accepted samples advance it.
    always_comb begin
        keep_c       = in_valid && (phase == PH_W'(DECIM - 1));
        phase_next_c = phase;
        if (in_valid) begin
            phase_next_c = keep_c ? '0 : PH_W'(phase + PH_W'(1));
        end
    end

    // Gain: widen by the maximum shift so the true product is never lost before clipping.
    always_comb begin
        ext_c       = EXT_W'($signed(in_data));
        shifted_c   = ext_c <<< gain_shift;
        gain_data_c = shifted_c[DATA_W-1:0];
        gain_clip_c = 1'b0;
        if (shifted_c > SAT_MAX) begin
            gain_data_c = SAT_MAX[DATA_W-1:0];
            gain_clip_c = 1'b1;
        end else if (shifted_c < SAT_MIN) begin
            gain_data_c = SAT_MIN[DATA_W-1:0];
            gain_clip_c = 1'b1;
        end
    end

    // FIFO control; a full FIFO still accepts when the head leaves in the same cycle.
    always_comb begin
        pop_c        = out_valid && out_ready;
        push_c       = stage_valid && ((level < LW'(FIFO_DEPTH)) || pop_c);
        drop_c       = stage_valid && !push_c;
        wr_next_c    = push_c ? AW'(wr_ptr + AW'(1)) : wr_ptr;
        rd_next_c    = pop_c  ? AW'(rd_ptr + AW'(1)) : rd_ptr;
        level_next_c = level;
        if (push_c && !pop_c) begin
            level_next_c = LW'(level + LW'(1));
        end else if (!push_c && pop_c) begin
            level_next_c = LW'(level - LW'(1));
        end
        head_next_c = '0;
        if (level_next_c != '0) begin
            head_next_c = (push_c && (wr_ptr == rd_next_c)) ? stage_data : mem[rd_next_c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= '0;
            stage_data  <= '0;
            stage_valid <= 1'b0;
            stage_clip  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            overflow    <= 1'b0;
            sat         <= 1'b0;
        end else begin
            phase       <= phase_next_c;
            stage_data  <= gain_data_c;
            stage_valid <= keep_c;
            stage_clip  <= keep_c && gain_clip_c;
            wr_ptr      <= wr_next_c;
            rd_ptr      <= rd_next_c;
            level       <= level_next_c;
            out_valid   <= (level_next_c != '0);
            out_data    <= head_next_c;
            // A set event in the same cycle as a clear takes priority.
            overflow    <= (overflow && !clr_flags) || drop_c;
            sat         <= (sat && !clr_flags) || (stage_valid && stage_clip);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= stage_data;
        end
    end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Randomized scoreboard bench for fir_decim_fifo against a queue-based reference model.
module tb_fir_decim_fifo;

    localparam int unsigned DATA_W     = 24;
    localparam int unsigned DECIM      = 4;
    localparam int unsigned FIFO_DEPTH = 8;

    logic                        clk;
    logic                        rst_n;
    logic [DATA_W-1:0]           in_data;
    logic                        in_valid;
    logic [2:0]                  gain_shift;
    logic [DATA_W-1:0]           out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [$clog2(FIFO_DEPTH):0] level;
    logic                        overflow;
    logic                        sat;
    logic                        clr_flags;

    fir_decim_fifo #(
        .DATA_W     (DATA_W),
        .DECIM      (DECIM),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .gain_shift (gain_shift),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow),
        .sat        (sat),
        .clr_flags  (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DATA_W-1:0] exp_q[$];
    int                m_level;
    bit                m_ovf;
    bit                m_sat;
    int                n_acc;
    bit                st_v;
    bit                st_c;
    logic [DATA_W-1:0] st_d;

    int checks;
    int errors;
    int rd_idx;

    // Reference model: count accepted inputs, clip with integer arithmetic, track occupancy.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_acc   = 0;
            st_v    = 0;
            st_c    = 0;
            st_d    = '0;
            m_level = 0;
            m_ovf   = 0;
            m_sat   = 0;
        end else begin
            bit     pop;
            bit     drop;
            longint v;
            longint hi;
            longint lo;
            pop  = (m_level > 0) && out_ready;
            drop = 0;
            if (st_v) begin
                if (m_level < int'(FIFO_DEPTH) || pop) begin
                    exp_q.push_back(st_d);
                    m_level++;
                end else begin
                    drop = 1;
                end
            end
            if (pop) m_level--;
            m_ovf = (m_ovf && !clr_flags) || drop;
            m_sat = (m_sat && !clr_flags) || (st_v && st_c);
            st_v  = 0;
            st_c  = 0;
            if (in_valid) begin
                n_acc++;
                if (n_acc % DECIM == 0) begin
                    hi = (longint'(1) <<< (DATA_W - 1)) - 1;
                    lo = -(longint'(1) <<< (DATA_W - 1));
                    v  = longint'($signed(in_data)) * (longint'(1) <<< gain_shift);
                    if (v > hi) begin v = hi; st_c = 1; end
                    else if (v < lo) begin v = lo; st_c = 1; end
                    st_d = v[DATA_W-1:0];
                    st_v = 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: advances the scoreboard on DUT pops, compares outputs on the falling edge.
    initial begin
        checks = 0;
        errors = 0;
        rd_idx = 0;
        forever begin
            @(posedge clk or negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                rd_idx = exp_q.size();
                chk("rst_out_valid", longint'(out_valid), 0);
                chk("rst_level", longint'(level), 0);
                chk("rst_out_data", longint'(out_data), 0);
                chk("rst_overflow", longint'(overflow), 0);
                chk("rst_sat", longint'(sat), 0);
            end else if (clk) begin
                if (out_valid && out_ready) rd_idx++;
            end else begin
                chk("out_valid", longint'(out_valid), longint'(m_level > 0));
                chk("level", longint'(level), longint'(m_level));
                chk("overflow", longint'(overflow), longint'(m_ovf));
                chk("sat", longint'(sat), longint'(m_sat));
                if (out_valid) begin
                    if (rd_idx < exp_q.size()) begin
                        chk("out_data", longint'(out_data), longint'(exp_q[rd_idx]));
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL out_data_extra actual=%0h required=none at %0t", out_data, $time);
                    end
                end else begin
                    chk("out_data_empty", longint'(out_data), 0);
                end
            end
        end
    end

    task automatic step(input bit v, input logic [DATA_W-1:0] d, input logic [2:0] g,
                        input bit rdy, input bit clr);
        @(negedge clk);
        in_valid   = v;
        in_data    = d;
        gain_shift = g;
        out_ready  = rdy;
        clr_flags  = clr;
    endtask

    initial begin
        logic [DATA_W-1:0] sat_vals [3];
        logic [2:0]        sat_gain [3];
        logic [DATA_W-1:0] rd;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        gain_shift = '0;
        out_ready  = 1'b0;
        clr_flags  = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Decimated ramp with free-flowing consumer
        for (int i = 1; i <= 40; i++) step(1, DATA_W'(i), 3'd0, 1, 0);

        // Saturation cases, each value held for a full decimation window
        sat_vals[0] = 24'h100000; sat_gain[0] = 3'd3;
        sat_vals[1] = 24'hF00000; sat_gain[1] = 3'd3;
        sat_vals[2] = 24'h100000; sat_gain[2] = 3'd2;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < DECIM; j++) step(1, sat_vals[k], sat_gain[k], 1, 0);
        repeat (4) step(0, '0, 3'd0, 1, 0);
        step(0, '0, 3'd0, 1, 1);
        repeat (3) step(0, '0, 3'd0, 1, 0);

        // Backpressure into overflow, then drain
        for (int i = 1; i <= 36; i++) step(1, DATA_W'(i), 3'd0, 0, 0);
        repeat (4) step(0, '0, 3'd0, 0, 0);
        repeat (12) step(0, '0, 3'd0, 1, 0);
        step(0, '0, 3'd0, 1, 1);

        // Fill, then sparse pops so pushes collide with pops at full
        for (int i = 1; i <= 32; i++) step(1, DATA_W'(i + 100), 3'd0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, DATA_W'(i + 200), 3'd0, (i % 4) == 1, 0);

        // Clear racing with drops, then a clear on its own
        for (int i = 0; i < 24; i++) step(1, DATA_W'(i + 300), 3'd1, 0, (i % 3) == 0);
        step(0, '0, 3'd0, 0, 1);
        repeat (12) step(0, '0, 3'd0, 1, 0);

        // Reset mid-stream with several samples buffered
        for (int i = 1; i <= 20; i++) step(1, DATA_W'(i + 400), 3'd0, 0, 0);
        repeat (2) step(0, '0, 3'd0, 0, 0);
        @(negedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) step(1, DATA_W'(i + 500), 3'd0, 1, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rd = ($urandom_range(0, 1) == 1) ? DATA_W'($urandom)
                                             : DATA_W'($signed(12'($urandom)));
            step($urandom_range(0, 3) != 0, rd, 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 2 : 8)),
                 $urandom_range(0, 15) == 0);
        end

        repeat (30) step(0, '0, 3'd0, 1, 0);
        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_decim_fifo.md
# fir_decim_fifo

Output stage directly downstream of the 101-tap low-pass FIR. It takes the FIR's 24-bit signed output stream and decimates it by a fixed factor. Each kept sample gets a programmable power-of-two gain with saturation. Results are buffered in a small first-word-fall-through FIFO and presented to the consumer over a valid/ready interface, with sticky overflow and saturation flags.

## Interface
- DATA_W, 24, sample width (signed two's complement) on input and output
- DECIM, 4, decimation factor (≥1); one of every DECIM accepted input samples is kept
- FIFO_DEPTH, 8, output buffer depth in samples (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  DATA_W  signed sample from FIR data_out
- in_valid  in  1  sample qualifier; tied high when the FIR free-runs
- gain_shift  in  3  left-shift amount 0..7, sampled with each kept sample
- out_data  out  DATA_W  signed FIFO head; 0 when empty
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts head when high with out_valid
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full
- sat  out  1  sticky: a kept sample was clipped by the gain stage
- clr_flags  in  1  synchronous clear of overflow and sat

## Operation
- Phase counter 0..DECIM-1, advances only on in_valid=1, wraps to 0.
  - A sample is kept when in_valid=1 and phase==DECIM-1.
  - After reset, the first kept sample is the DECIM-th accepted input.
  - DECIM=1 keeps every valid sample.
- Gain stage:
  - Compute in_data <<< gain_shift in DATA_W+7 bits.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1], i.e. 0x800000..0x7FFFFF for the default width.
  - Set a clip bit if the value was limited.
  - Register the result in a single pipeline stage: stage_data, stage_valid, stage_clip.
- FIFO push when stage_valid=1:
  - Write if level<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise drop the sample and set overflow.
  - A dropped sample never corrupts stored data.
- FIFO pop when out_valid && out_ready. out_data always shows the oldest entry (fall-through). Samples leave in arrival order.
- Level update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged, including at full and with level==1.
- Flags:
  - sat sets on a stage_clip that is pushed or dropped.
  - overflow sets on a drop.
  - clr_flags clears both flags. If a set event occurs in the same cycle as clr_flags, the set wins.
- Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): phase=0, stage_valid=0, FIFO empty, level=0, out_valid=0, out_data=0, overflow=0, sat=0.
- Latency from a kept sample's acceptance:
  - Edge E: stage register loaded.
  - Edge E+1: FIFO written.
  - Cycle after E+1: out_valid=1 and out_data valid (2 edges total).
- The consumer sees a pop effective at the edge where out_valid && out_ready. The next head appears in the following cycle.
- Sustained throughput: one kept sample per DECIM valid inputs. The FIFO never fills if out_ready is high at least 1 of every DECIM cycles.
- Reset mid-operation discards all buffered and in-flight samples and restarts the phase count.
- gain_shift and clr_flags are synchronous. No combinational path from in_data to any output.

## Test plan
- Decimate ramp: DECIM=4, gain 0, out_ready=1, in_data=1,2,3,… every cycle -> out_data=4,8,12,16…; first out_valid 2 edges after the edge accepting 4; sat=0, overflow=0.
- Saturation: kept in_data=0x100000 with gain 3 -> 0x7FFFFF, sat=1. Kept 0xF00000 with gain 3 -> 0x800000. Kept 0x100000 with gain 2 -> 0x400000. After clr_flags, sat=0.
- Backpressure and overflow: out_ready=0, feed 36 ramp samples -> level=8 after the 8th kept sample, 9th kept sample dropped, overflow=1. Then out_ready=1 -> drains 4,8,…,32 in order; out_valid low after the 8th pop; level=0.
- Full with simultaneous push/pop: level=8, out_ready=1 on the cycle stage_valid=1 -> level stays 8, overflow stays 0, and the new sample appears after the 7 older ones.
- Clear-vs-set: clr_flags=1 in the same cycle as a drop -> overflow=1. clr_flags=1 alone on a later cycle -> overflow=0.
- Reset mid-stream: with level=5, pulse rst_n low -> out_valid=0, level=0, out_data=0 immediately. After release, the first output equals the 4th input accepted after reset.
